// File: rtl/dash_pkg.sv
// Shared types and constants for the dash LED animator.
package dash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SWEEP    = 2'd1,
    ST_COOLDOWN = 2'd2
  } dash_state_e;

  localparam int unsigned NUM_LEDS   = 16;
  localparam int unsigned NUM_FRAMES = 16;

  localparam logic [NUM_LEDS-1:0] BAR_LEFT_INIT  = 16'h000F;
  localparam logic [NUM_LEDS-1:0] BAR_RIGHT_INIT = 16'hF000;

endpackage

// File: rtl/dash_step_timer.sv
// Free-running step timer: counts 0..last while enabled and pulses tick_c on the last count.
module dash_step_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tick_c
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_c = en && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick_c ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dash_led_animator.sv
// Dash LED animator: 16-frame directional sweep followed by a timed cooldown.
// Define DASH_COOLDOWN_BAR_EN to show a filling bar during cooldown (dark otherwise).
module dash_led_animator
  import dash_pkg::*;
#(
  parameter int unsigned STEP_CYCLES      = 2_500_000,
  parameter int unsigned COOL_STEP_CYCLES = 3_125_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dash_trigger,
  input  logic        player_facing_left,
  output logic [15:0] led,
  output logic        dash_ready
);

  localparam int unsigned MAX_CYCLES = (STEP_CYCLES > COOL_STEP_CYCLES) ? STEP_CYCLES
                                                                        : COOL_STEP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_STEP_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_FRAMES - 1);

  dash_state_e state_q, state_d;
  logic        dir_left_q, dir_left_d;
  logic [3:0]  frame_q, frame_d;
  logic [3:0]  seg_q, seg_d;
  logic [15:0] led_q, led_d;
  logic        ready_q, ready_d;
  logic        trig_prev_q, trig_prev_d;

  logic             trig_edge_c;
  logic             tick_c;
  logic [CNT_W-1:0] timer_last_c;

  assign trig_edge_c = dash_trigger && !trig_prev_q;

  dash_step_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_IDLE),
    .en     (state_q != ST_IDLE),
    .last   (timer_last_c),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d      = state_q;
    dir_left_d   = dir_left_q;
    frame_d      = frame_q;
    seg_d        = seg_q;
    trig_prev_d  = dash_trigger;
    timer_last_c = STEP_LAST;
    led_d        = 16'h0000;
    ready_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_edge_c) begin
          state_d    = ST_SWEEP;
          dir_left_d = player_facing_left;
          frame_d    = 4'd0;
        end
      end
      ST_SWEEP: begin
        if (tick_c) begin
          if (frame_q == LAST_IDX) begin
            state_d = ST_COOLDOWN;
            frame_d = 4'd0;
            seg_d   = 4'd0;
          end else begin
            frame_d = frame_q + 4'd1;
          end
        end
      end
      ST_COOLDOWN: begin
        timer_last_c = COOL_LAST;
        if (tick_c) begin
          if (seg_q == LAST_IDX) begin
            state_d = ST_IDLE;
            seg_d   = 4'd0;
          end else begin
            seg_d = seg_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are derived from the next state so they change on the transition edge.
    case (state_d)
      ST_SWEEP: led_d = dir_left_d ? (BAR_LEFT_INIT << frame_d) : (BAR_RIGHT_INIT >> frame_d);
`ifdef DASH_COOLDOWN_BAR_EN
      ST_COOLDOWN: led_d = ~(16'hFFFE << seg_d);
`endif
      default: led_d = 16'h0000;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_left_q  <= 1'b0;
      frame_q     <= 4'd0;
      seg_q       <= 4'd0;
      led_q       <= 16'h0000;
      ready_q     <= 1'b1;
      trig_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      dir_left_q  <= dir_left_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      led_q       <= led_d;
      ready_q     <= ready_d;
      trig_prev_q <= trig_prev_d;
    end
  end

  assign led        = led_q;
  assign dash_ready = ready_q;

endmodule

// File: tb/tb_dash_led_animator.sv
// Directed bench for dash_led_animator with STEP_CYCLES=4, COOL_STEP_CYCLES=2.
module tb_dash_led_animator;

  logic        clk;
  logic        reset;
  logic        dash_trigger;
  logic        player_facing_left;
  logic [15:0] led;
  logic        dash_ready;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  logic [15:0] left_tbl [16] = '{
    16'h000F, 16'h001E, 16'h003C, 16'h0078, 16'h00F0, 16'h01E0, 16'h03C0, 16'h0780,
    16'h0F00, 16'h1E00, 16'h3C00, 16'h7800, 16'hF000, 16'hE000, 16'hC000, 16'h8000};
  logic [15:0] right_tbl [16] = '{
    16'hF000, 16'h7800, 16'h3C00, 16'h1E00, 16'h0F00, 16'h0780, 16'h03C0, 16'h01E0,
    16'h00F0, 16'h0078, 16'h003C, 16'h001E, 16'h000F, 16'h0007, 16'h0003, 16'h0001};
  logic [15:0] bar_tbl [16] = '{
    16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F, 16'h003F, 16'h007F, 16'h00FF,
    16'h01FF, 16'h03FF, 16'h07FF, 16'h0FFF, 16'h1FFF, 16'h3FFF, 16'h7FFF, 16'hFFFF};

  dash_led_animator #(
    .STEP_CYCLES      (4),
    .COOL_STEP_CYCLES (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .dash_trigger       (dash_trigger),
    .player_facing_left (player_facing_left),
    .led                (led),
    .dash_ready         (dash_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_led"}, 32'(led), 32'h0);
    check_eq({tag, "_rdy"}, 32'(dash_ready), 32'h1);
  endtask

  // One full dash: sweep then cooldown, ending one cycle into IDLE.
  task automatic run_dash(input logic left, input logic hold, input logic inject);
    logic [15:0] exp;
    dash_trigger       = 1'b1;
    player_facing_left = left;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp = left ? left_tbl[k] : right_tbl[k];
        check_eq($sformatf("sweep_k%0d_c%0d", k, c), 32'(led), 32'(exp));
        check_eq($sformatf("sweep_rdy_k%0d", k), 32'(dash_ready), 32'h0);
        if (k == 0 && c == 0 && !hold) dash_trigger = 1'b0;
        if (inject && k == 5 && c == 0) begin
          dash_trigger       = 1'b1;
          player_facing_left = !left;
        end
        if (inject && k == 6 && c == 0) dash_trigger = 1'b0;
      end
    end
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 2; c++) begin
        step();
`ifdef DASH_COOLDOWN_BAR_EN
        exp = bar_tbl[s];
`else
        exp = 16'h0000;
`endif
        check_eq($sformatf("cool_s%0d_c%0d", s, c), 32'(led), 32'(exp));
        check_eq($sformatf("cool_rdy_s%0d", s), 32'(dash_ready), 32'h0);
      end
    end
    step();
    check_idle("dash_end");
  endtask

  initial begin
    reset              = 1'b1;
    dash_trigger       = 1'b0;
    player_facing_left = 1'b1;
    repeat (3) step();
    check_idle("in_reset");
    reset = 1'b0;
    step();
    check_idle("after_reset");

    run_dash(1'b1, 1'b0, 1'b0);
    repeat (2) begin step(); check_idle("idle_after_left"); end

    run_dash(1'b0, 1'b0, 1'b0);
    repeat (2) begin step(); check_idle("idle_after_right"); end

    run_dash(1'b1, 1'b0, 1'b1);
    player_facing_left = 1'b1;
    repeat (4) begin step(); check_idle("no_restart"); end

    run_dash(1'b0, 1'b1, 1'b0);
    repeat (3) begin step(); check_idle("held_trig"); end
    dash_trigger = 1'b0;
    step();
    check_idle("held_release");

    // Second dash starts with its edge in the first IDLE cycle of the first.
    run_dash(1'b1, 1'b0, 1'b0);
    run_dash(1'b0, 1'b0, 1'b0);

    dash_trigger       = 1'b1;
    player_facing_left = 1'b1;
    repeat (29) step();
    check_eq("rst_frame7", 32'(led), 32'h0780);
    reset = 1'b1;
    step();
    check_idle("rst_abort");
    repeat (2) step();
    reset = 1'b0;
    repeat (4) begin step(); check_idle("rst_held_trig"); end
    dash_trigger = 1'b0;
    step();
    check_idle("rst_trig_low");
    dash_trigger = 1'b1;
    step();
    check_eq("rst_rearm_led", 32'(led), 32'h000F);
    check_eq("rst_rearm_rdy", 32'(dash_ready), 32'h0);
    dash_trigger = 1'b0;
    reset        = 1'b1;
    step();
    check_idle("final_reset");

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
